// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_pkg
// Description : Shared types and constants for the nibble-serial adder
//               sequencer (FSM state encoding, slice width).
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_pkg;

  // Width of the shared adder slice; the operands are walked in steps of this.
  localparam int NIBBLE_W = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : nibble_serial_adder_pkg
`default_nettype wire

// File: rtl/four_bit_adder_verilog.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_adder_verilog
// Description : Purely combinational 4-bit ripple-carry adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
module four_bit_adder_verilog (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  // Carry chain: w_carry[k] is the carry into bit k.
  logic [4:0] w_carry;

  assign w_carry[0] = i_cin;

  // One full adder per bit, rippling the carry upward.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign o_sum[gi]       = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (i_a[gi] & i_b[gi]) |
                             (i_a[gi] & w_carry[gi]) |
                             (i_b[gi] & w_carry[gi]);
  end

  assign o_cout = w_carry[4];

endmodule : four_bit_adder_verilog
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Adds two WIDTH-bit operands by reusing one 4-bit ripple-carry
//               slice, one nibble per clock, least-significant nibble first.
//               Start/busy/done handshake; result and carry-out registered.
//               Optional macro NIBBLE_SERIAL_ADDER_SUB_EN adds i_Sub
//               (subtract A-B) and o_Ovf (signed overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Cin,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Cout
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  ,
  input  logic             i_Sub,
  output logic             o_Ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] C_LAST_NIB = CNT_W'(NIBBLES - 1);

  state_t              r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_sum;
  logic                r_carry;
  logic [CNT_W-1:0]    r_cnt;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum_nib;
  logic                w_cout;
  logic [WIDTH-1:0]    w_sum_next;
  logic [WIDTH-1:0]    w_b_load;
  logic                w_c_load;

  // Operand conditioning at acceptance: subtraction is A + ~B + 1.
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic w_c_msb;
  logic w_ovf;

  assign w_b_load = i_Sub ? ~i_B : i_B;
  assign w_c_load = i_Sub ? 1'b1 : i_Cin;
  // Carry into the top bit of the slice, recovered from its sum bit.
  assign w_c_msb  = w_sum_nib[NIBBLE_W-1] ^ w_a_nib[NIBBLE_W-1] ^ w_b_nib[NIBBLE_W-1];
  assign w_ovf    = w_c_msb ^ w_cout;
`else
  assign w_b_load = i_B;
  assign w_c_load = i_Cin;
`endif

  // Select the nibble currently being worked on.
  assign w_a_nib = r_a[NIBBLE_W*int'(r_cnt) +: NIBBLE_W];
  assign w_b_nib = r_b[NIBBLE_W*int'(r_cnt) +: NIBBLE_W];

  four_bit_adder_verilog u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_sum_nib),
    .o_cout (w_cout)
  );

  // Working sum with the current nibble merged in.
  always_comb begin
    w_sum_next = r_sum;
    w_sum_next[NIBBLE_W*int'(r_cnt) +: NIBBLE_W] = w_sum_nib;
  end

  assign o_Busy = (r_state != IDLE);

  // Sequencer: accept operands, walk the nibbles, publish the result.
  // The result registers load on the edge that finishes the last nibble, so
  // they are already stable during the DONE cycle in which o_Done is high.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      o_Done  <= 1'b0;
      o_Sum   <= '0;
      o_Cout  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      o_Ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          o_Done <= 1'b0;
          if (i_Start) begin
            r_a     <= i_A;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          if (r_cnt == C_LAST_NIB) begin
            o_Sum   <= w_sum_next;
            o_Cout  <= w_cout;
            o_Done  <= 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            o_Ovf   <= w_ovf;
`endif
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          o_Done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          o_Done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : nibble_serial_adder_ctrl
`default_nettype wire
